ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
AHB slave (responder) fronting an on-chip word-organised SRAM model with a configurable wait-state count and a read-only low region. It is the opposite end of the master-side AHB nets carried by the SoC AHB connect interface. The AHB decoder drives hsel. The block answers master transfers with hreadyout, hresp and hrdata. Used as a bus-level memory target in SoC env and subsystem builds.

Parameters:
MEM_BYTES, 4096, memory size in bytes; power of two, at least 4; ADDR_W = log2(MEM_BYTES).
WAIT_STATES, 0, wait cycles inserted in every accepted OKAY data phase; range 0..15.
RO_BYTES, 0, byte offsets below this are read-only; multiple of 4, at most MEM_BYTES.

Ports:
clock  input  1  bus clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
hsel  input  1  slave select from the decoder.
haddr  input  32  byte address; only [ADDR_W-1:0] is used.
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
hwrite  input  1  1 = write.
hsize  input  3  0 = byte, 1 = half, 2 = word; values above 2 are illegal.
hburst  input  3  accepted and ignored; each beat is handled independently.
hprot  input  4  accepted and ignored.
hwdata  input  32  write data, valid in the data phase.
hready  input  1  bus-wide ready; an address phase completes only when this is 1.
hreadyout  output  1  this slave's ready.
hresp  output  2  OKAY=00, ERROR=01; RETRY and SPLIT are never driven.
hrdata  output  32  read data.

Behaviour:
- Reset (reset=1 at a clock edge):
  - hreadyout=1, hresp=00, hrdata=0.
  - FSM goes to IDLE; wait counter=0; pending write is cleared.
  - Memory contents are not reset.
- Address phase is accepted when hsel & hready & htrans[1] at a clock edge. The block then latches addr, write, size and the error flag.
- An accepted transfer is an error if any of these holds:
  - hsize > 2;
  - hsize=1 and addr[0]=1;
  - hsize=2 and addr[1:0] != 0;
  - the transfer is a write and addr < RO_BYTES.
- IDLE or BUSY with hsel, or any cycle without hsel: zero-wait OKAY; no memory access.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - hreadyout=1, hresp=00.
  - Accepted error transfer -> ERR1.
  - Accepted OKAY transfer with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES.
  - Accepted OKAY transfer with WAIT_STATES=0 -> stay in IDLE; the data phase completes in the next cycle.
- WAIT:
  - hreadyout=0, hresp=00; counter decrements each cycle.
  - When counter reaches 1, the next cycle drives hreadyout=1 (data phase completes) and the FSM re-evaluates the address phase as in IDLE.
  - Total data-phase length is WAIT_STATES+1 cycles.
- ERR1: hreadyout=0, hresp=01, then -> ERR2 unconditionally.
- ERR2: hreadyout=1, hresp=01; accepts a new address phase exactly as IDLE does.
- Error transfers never modify memory. hrdata=0 during ERR1 and ERR2.
- Read data:
  - hrdata = mem[addr[ADDR_W-1:2]] combinationally while in a read data phase with hreadyout=1.
  - The full word is returned regardless of hsize; the master selects the byte lanes.
  - hrdata=0 otherwise.
- Write data:
  - hwdata is sampled at the final data-phase edge (hreadyout=1). Byte lanes are little-endian.
  - Byte: lane addr[1:0] written. Half: lanes {addr[1],0} and {addr[1],1} written. Word: all 4 lanes written.
  - The write commits on that same edge, so a read of the same word in the immediately following data phase returns the new data.
- Back-to-back pipelined transfers are supported: a new address phase overlaps the previous data phase's final cycle.
- hready=0 from another slave's data phase: the address phase is not accepted and is held by the master; no state change.
- Reset asserted mid-transfer: the transfer is abandoned and any pending write is dropped.

Decomposition:
- Package ahb_pkg holds:
  - enums htrans_e (IDLE, BUSY, NONSEQ, SEQ), hresp_e (OKAY, ERROR, RETRY, SPLIT), hsize_e (BYTE, HALF, WORD);
  - typedef ahb_slv_state_e (IDLE, WAIT, ERR1, ERR2).
- One sub-module, ahb_sram_bytelane_mem: word-addressed array with a 4-bit byte-enable write port and an asynchronous read port.
- The top level holds the FSM, wait counter, error check and byte-enable generation.

Test Plan:
- Reset, then WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> read returns 0xDEADBEEF in the cycle after its address phase; hreadyout stays 1 throughout.
- WAIT_STATES=3: NONSEQ read @0x20 -> hreadyout low for exactly 3 cycles, then high with the data; hresp=00.
- After word 0x00000000 @0x40: byte write 0xAA to 0x41, then half write 0x1234 to 0x42 -> a word read of 0x40 returns 0x1234AA00.
- Misaligned word write @0x06 -> ERR1 (hreadyout=0, hresp=01), then ERR2 (hreadyout=1, hresp=01); a read of 0x04 is unchanged.
- RO_BYTES=0x100: write to 0xFC gets a two-cycle ERROR response; write to 0x100 gets OKAY; a prior read of 0xFC shows the original contents.
- Back-to-back write @0x80 then read @0x80 with WAIT_STATES=0 -> read returns the new data. Then assert reset during a WAIT cycle -> next cycle hreadyout=1, hresp=00 and the pending write is not committed.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the SRAM slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Slave FSM state; plain vector so older tools that dump raw codes stay happy.
  typedef logic [1:0] ahb_slv_state_e;
  localparam ahb_slv_state_e ST_IDLE = 2'd0;
  localparam ahb_slv_state_e ST_WAIT = 2'd1;
  localparam ahb_slv_state_e ST_ERR1 = 2'd2;
  localparam ahb_slv_state_e ST_ERR2 = 2'd3;

  // Illegal size or misaligned address for the given size.
  function automatic logic size_err(input logic [2:0] size, input logic [1:0] lo);
    return (size > 3'd2) ||
           ((size == 3'd1) && lo[0]) ||
           ((size == 3'd2) && (lo != 2'b00));
  endfunction

  // Little-endian byte-lane enables for a legal, aligned transfer.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'd0:    return 4'b0001 << lo;
      3'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_bytelane_mem.sv
// Word-organised memory: byte-enabled synchronous write, asynchronous read.
module ahb_sram_bytelane_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Commit the enabled byte lanes; contents are deliberately never reset.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB responder in front of a word SRAM with wait states and a read-only low region.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0,
  parameter int RO_BYTES    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int WORDS  = MEM_BYTES / 4;
  localparam int WA_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  // Burst type, protection and the unused address bits carry no meaning here.
  logic unused_in;
  assign unused_in = ^{hburst, hprot, haddr[31:ADDR_W], htrans[0]};

  ahb_slv_state_e    state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] d_addr;
  logic              d_write;
  logic [2:0]        d_size;
  logic              d_active;  // an accepted OKAY transfer is in its data phase

  logic [ADDR_W-1:0] a_addr;
  logic              accept;
  logic              ro_hit;
  logic              a_err;

  assign a_addr = haddr[ADDR_W-1:0];
  assign accept = hsel & hready & htrans[1];

  if (RO_BYTES > 0) begin : g_ro
    assign ro_hit = hwrite & ({1'b0, a_addr} < (ADDR_W+1)'(RO_BYTES));
  end else begin : g_no_ro
    assign ro_hit = 1'b0;
  end

  assign a_err = size_err(hsize, a_addr[1:0]) | ro_hit;

  // Data-phase outputs follow the FSM; ERR1 is the stalled first error cycle.
  assign hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
  assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  // Address-phase capture, wait counting and the two-cycle error response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      d_addr   <= '0;
      d_write  <= 1'b0;
      d_size   <= '0;
      d_active <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_IDLE;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          // IDLE and ERR2 both end a data phase and may take a new address phase.
          if (accept) begin
            d_addr  <= a_addr;
            d_write <= hwrite;
            d_size  <= hsize;
            if (a_err) begin
              state    <= ST_ERR1;
              d_active <= 1'b0;
            end else if (WS != 4'd0) begin
              state    <= ST_WAIT;
              cnt      <= WS;
              d_active <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              d_active <= 1'b1;
            end
          end else begin
            state    <= ST_IDLE;
            d_active <= 1'b0;
          end
        end
      endcase
    end
  end

  // Writes land on the final data-phase edge so the next data phase sees them.
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [WA_W-1:0] mem_addr;
  logic [31:0]     mem_rdata;

  assign mem_we   = d_active & d_write & hreadyout & ~reset;
  assign mem_be   = byte_en(d_size, d_addr[1:0]);
  assign mem_addr = WA_W'(d_addr >> 2);

  ahb_sram_bytelane_mem #(
    .WORDS (WORDS),
    .AW    (WA_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  // Full word is returned; the master picks the lanes it asked for.
  assign hrdata = (d_active & ~d_write & hreadyout) ? mem_rdata : 32'h0;

endmodule
